// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes non-memory instructions to writeback and runs one
// big-endian bus transaction per load/store. Optional alignment trap: MEM_ALIGN_CHECK_EN.
module mem_access (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [2:0]  ccr_i,
  input  logic [1:0]  reg_write_i,
  input  logic [31:0] result_i,
  input  logic [31:0] data_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [2:0]  ccr_o,
  output logic [1:0]  reg_write_o,
  output logic [31:0] result_o,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic        fault_o
);

  localparam logic [3:0] T_LOAD  = 4'h8;
  localparam logic [3:0] T_STORE = 4'h9;

  typedef enum logic {IDLE, BUS} state_e;

  state_e      state_q, state_d;
  logic [63:0] ir_q, ir_d, capIr_q, capIr_d;
  logic [31:0] pc_q, pc_d, capPc_q, capPc_d;
  logic [2:0]  ccr_q, ccr_d, capCcr_q, capCcr_d;
  logic [1:0]  rw_q, rw_d, capRw_q, capRw_d;
  logic [31:0] result_q, result_d, addr_q, addr_d, stData_q, stData_d;
  logic [31:0] doneResult_q, doneResult_d;
  logic [1:0]  size_q, size_d;
  logic        isStore_q, isStore_d, done_q, done_d, doneFault_q, doneFault_d;
  logic        fault_q, fault_d;

  logic        isMem, isStoreIn, misalign, busActive, termNow, presentNow, presentFault;
  logic [3:0]  laneSel;
  logic [31:0] storeData, loadData, termResult, presentResult;
  logic [1:0]  sizeIn;

  assign isStoreIn = (ir_i[31:28] == T_STORE);
  assign isMem     = (ir_i[31:28] == T_LOAD) || isStoreIn;
  assign sizeIn    = ir_i[25:24];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = isMem && (((sizeIn == 2'd1) && result_i[0]) ||
                              (((sizeIn == 2'd0) || (sizeIn == 2'd3)) && (result_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Big-endian lane steering: lowest address byte lives on bits 31:24.
  always_comb begin
    laneSel   = 4'b1111;
    storeData = stData_q;
    loadData  = bus_dat_i;
    case (size_q)
      2'd1: begin
        laneSel   = addr_q[1] ? 4'b0011 : 4'b1100;
        storeData = {2{stData_q[15:0]}};
        loadData  = {16'h0, (addr_q[1] ? bus_dat_i[15:0] : bus_dat_i[31:16])};
      end
      2'd2: begin
        storeData = {4{stData_q[7:0]}};
        case (addr_q[1:0])
          2'd0: begin laneSel = 4'b1000; loadData = {24'h0, bus_dat_i[31:24]}; end
          2'd1: begin laneSel = 4'b0100; loadData = {24'h0, bus_dat_i[23:16]}; end
          2'd2: begin laneSel = 4'b0010; loadData = {24'h0, bus_dat_i[15:8]};  end
          default: begin laneSel = 4'b0001; loadData = {24'h0, bus_dat_i[7:0]}; end
        endcase
      end
      default: ;
    endcase
  end

  assign busActive = (state_q == BUS) && !done_q;
  assign bus_cyc   = busActive;
  assign bus_stb   = busActive;
  assign bus_we    = busActive && isStore_q;
  assign bus_adr   = busActive ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_sel   = busActive ? laneSel : 4'b0000;
  assign bus_dat_o = (busActive && isStore_q) ? storeData : 32'h0;
  assign stall_o   = stall_i || (state_q == BUS);

  // A termination seen under stall parks in done_q; the stage stays in BUS until it can hand off.
  assign termNow       = busActive && (bus_ack || bus_err);
  assign termResult    = bus_err ? 32'h0 : (isStore_q ? addr_q : loadData);
  assign presentNow    = (state_q == BUS) && !stall_i && (termNow || done_q);
  assign presentResult = done_q ? doneResult_q : termResult;
  assign presentFault  = done_q ? doneFault_q : bus_err;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    ccr_d        = ccr_q;
    rw_d         = rw_q;
    result_d     = result_q;
    fault_d      = 1'b0;
    capIr_d      = capIr_q;
    capPc_d      = capPc_q;
    capCcr_d     = capCcr_q;
    capRw_d      = capRw_q;
    addr_d       = addr_q;
    stData_d     = stData_q;
    size_d       = size_q;
    isStore_d    = isStore_q;
    done_d       = done_q;
    doneResult_d = doneResult_q;
    doneFault_d  = doneFault_q;
    case (state_q)
      IDLE: begin
        if (!stall_i) begin
          if (misalign) begin
            ir_d     = ir_i;
            pc_d     = pc_i;
            ccr_d    = ccr_i;
            rw_d     = 2'b00;
            result_d = result_i;
            fault_d  = 1'b1;
          end else if (isMem) begin
            capIr_d   = ir_i;
            capPc_d   = pc_i;
            capCcr_d  = ccr_i;
            capRw_d   = reg_write_i;
            addr_d    = result_i;
            stData_d  = data_i;
            size_d    = sizeIn;
            isStore_d = isStoreIn;
            done_d    = 1'b0;
            ir_d      = 64'h0;
            rw_d      = 2'b00;
            state_d   = BUS;
          end else begin
            ir_d     = ir_i;
            pc_d     = pc_i;
            ccr_d    = ccr_i;
            rw_d     = reg_write_i;
            result_d = result_i;
          end
        end
      end
      BUS: begin
        if (presentNow) begin
          ir_d     = capIr_q;
          pc_d     = capPc_q;
          ccr_d    = capCcr_q;
          rw_d     = presentFault ? 2'b00 : capRw_q;
          result_d = presentResult;
          fault_d  = presentFault;
          done_d   = 1'b0;
          state_d  = IDLE;
        end else if (termNow) begin
          done_d       = 1'b1;
          doneResult_d = termResult;
          doneFault_d  = bus_err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ir_q         <= '0;
      pc_q         <= '0;
      ccr_q        <= '0;
      rw_q         <= '0;
      result_q     <= '0;
      fault_q      <= 1'b0;
      capIr_q      <= '0;
      capPc_q      <= '0;
      capCcr_q     <= '0;
      capRw_q      <= '0;
      addr_q       <= '0;
      stData_q     <= '0;
      size_q       <= '0;
      isStore_q    <= 1'b0;
      done_q       <= 1'b0;
      doneResult_q <= '0;
      doneFault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      ccr_q        <= ccr_d;
      rw_q         <= rw_d;
      result_q     <= result_d;
      fault_q      <= fault_d;
      capIr_q      <= capIr_d;
      capPc_q      <= capPc_d;
      capCcr_q     <= capCcr_d;
      capRw_q      <= capRw_d;
      addr_q       <= addr_d;
      stData_q     <= stData_d;
      size_q       <= size_d;
      isStore_q    <= isStore_d;
      done_q       <= done_d;
      doneResult_q <= doneResult_d;
      doneFault_q  <= doneFault_d;
    end
  end

  assign ir_o        = ir_q;
  assign pc_o        = pc_q;
  assign ccr_o       = ccr_q;
  assign reg_write_o = rw_q;
  assign result_o    = result_q;
  assign fault_o     = fault_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have clk_i  input  1  clock; all state rising-edge.
REQ-002 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ir_i / pc_i / ccr_i / reg_write_i  input  64/32/3/2  instruction word, PC, condition codes and register-write code from execute.
REQ-004 SHALL have result_i  input  32  ALU result; the effective address for memory ops.
REQ-005 SHALL have data_i  input  32  store data (register B value).
REQ-006 SHALL have stall_i  input  1  writeback holding; stall_o  output  1  hold request to execute.
REQ-007 SHALL have ir_o / pc_o / ccr_o / reg_write_o / result_o  output  64/32/3/2/32  registered writeback-stage inputs.
REQ-008 SHALL have bus_cyc, bus_stb, bus_we  output  1 each; bus_sel  output  4; bus_adr, bus_dat_o  output  32  bus master signals.
REQ-009 SHALL have bus_dat_i  input  32, bus_ack  input  1, bus_err  input  1  bus slave response.
REQ-010 SHALL have fault_o  output  1  one-cycle memory-fault pulse.

Function
REQ-011 SHALL decode a memory op as ir_i[31:28] equal to T_LOAD or T_STORE; size = ir_i[25:24]: 0 word, 1 halfword, 2 byte, 3 treated as word.
REQ-012 SHALL implement FSM IDLE, BUS, with IDLE after reset.
REQ-013 IDLE, stall_i=0, non-memory op: SHALL register all *_i onto *_o next edge (1-cycle latency), result_o=result_i.
REQ-014 IDLE, stall_i=0, memory op: SHALL capture ir/pc/ccr/reg_write, address, store data, size; go to BUS; drive a bubble (ir_o=0, reg_write_o=0) that cycle.
REQ-015 BUS SHALL hold bus_cyc=bus_stb=1, bus_we=1 for store, bus_adr={addr[31:2],2'b00}, all bus signals stable until ack or err.
REQ-016 Byte lanes SHALL be big-endian: byte at addr[1:0]=0 on bits 31:24, sel 4'b1000; halfword at addr[1]=0 on 31:16, sel 4'b1100; word sel 4'b1111.
REQ-017 Stores SHALL replicate the data_i low byte/halfword across all lanes on bus_dat_o.
REQ-018 Loads SHALL extract the selected lane from bus_dat_i and zero-extend into result_o.
REQ-019 On bus_ack in BUS: next edge SHALL deassert cyc/stb, present captured instruction on *_o (result_o = load data, or address for store), return to IDLE.
REQ-020 On bus_err in BUS (err wins over simultaneous ack): SHALL end cycle as REQ-019 with result_o=0, reg_write_o=0, fault_o=1 for one cycle.
REQ-021 stall_o SHALL equal stall_i OR (state==BUS), combinationally.
REQ-022 While BUS and not yet terminated, *_o SHALL present the bubble.
REQ-023 stall_i=1 in IDLE: all *_o SHALL hold; no capture, no bus cycle started.
REQ-024 stall_i=1 when ack arrives: SHALL complete the bus cycle, hold the result internally, present it on the first edge with stall_i=0.
REQ-025 A load with reg_write_i=0 SHALL still perform the bus read.

Reset
REQ-026 rst_i SHALL force state IDLE and all outputs to 0 (bus_cyc/bus_stb low immediately), aborting any bus cycle; the aborted instruction is lost.

Configuration
REQ-027 With MEM_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL start no bus cycle, present the instruction with reg_write_o=0, result_o=address, fault_o=1 for one cycle, and stay IDLE.
REQ-028 Without MEM_ALIGN_CHECK_EN: misaligned low address bits SHALL be ignored (halfword uses addr[1], word uses none) and fault_o SHALL only respond to bus_err.

Verification
REQ-029 Add instruction, result_i=32'h1234 -> result_o=32'h1234 one edge later, no bus_cyc.
REQ-030 Byte load addr 32'h1001, bus_dat_i=32'hAABBCCDD, ack after 3 wait cycles -> bus_sel=4'b0100, stall_o high 4 cycles, result_o=32'h000000BB.
REQ-031 Halfword store addr 32'h2002, data_i=32'h0000BEEF -> bus_we=1, bus_sel=4'b0011, bus_dat_o=32'hBEEFBEEF.
REQ-032 Word load with bus_err and ack together -> result_o=0, reg_write_o=0, fault_o single pulse.
REQ-033 rst_i asserted mid-BUS -> bus_cyc low same cycle, state IDLE, outputs 0.
REQ-034 MEM_ALIGN_CHECK_EN, word load addr 32'h3002 -> no bus_cyc, fault_o pulse; undefined -> bus_adr=32'h3000, sel 4'b1111.
